// File: rtl/hwce_weight_buffer.sv
// HWCE weight/bias holding stage between the weight loader and the SoP engines.
// Define HWCE_WBUF_DOUBLE_EN for two banks with prefetch; default is one bank.
module hwce_weight_buffer #(
  parameter  int FILTER_SIZE = 3,
  parameter  int N_ROW       = 4,
  parameter  int N_COL       = 4,
  parameter  int NPF         = 3,
  localparam int K           = FILTER_SIZE * FILTER_SIZE * NPF,
  localparam int WW          = N_ROW * N_COL * K * 16,
  localparam int BW          = N_ROW * 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          job_start_i,
  input  logic [15:0]   n_sets_i,
  input  logic          clear_i,
  output logic          wl_start_o,
  input  logic          wl_done_i,
  input  logic [WW-1:0] wl_weights_i,
  input  logic [BW-1:0] wl_bias_i,
  output logic          eng_valid_o,
  output logic [WW-1:0] eng_weights_o,
  output logic [BW-1:0] eng_bias_o,
  output logic [15:0]   eng_set_idx_o,
  input  logic          eng_release_i,
  output logic          busy_o,
  output logic          job_done_o
);

`ifdef HWCE_WBUF_DOUBLE_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_LOADING,
    S_WAIT_FREE,
    S_DRAIN
  } state_t;

  state_t        r_state;
  state_t        w_next;

  logic [15:0]   r_n_sets;
  logic [15:0]   r_fetched;
  logic [15:0]   r_released;
  logic [NB-1:0] r_bank_valid;
  logic [WW-1:0] r_w [NB];
  logic [BW-1:0] r_b [NB];
  logic          r_zero_done;

  logic          w_clr;
  logic          w_wr_ptr;
  logic          w_rd_ptr;
  logic          w_start_ok;
  logic          w_cap;
  logic          w_rel;
  logic          w_last;
  logic          w_other_free;
  logic [NB-1:0] w_cap_mask;
  logic [NB-1:0] w_rel_mask;

  assign w_clr      = rst | clear_i;
  assign w_start_ok = (r_state == S_IDLE) && job_start_i
                      && (n_sets_i != 16'd0);
  assign w_cap      = (r_state == S_LOADING) && wl_done_i;
  assign w_rel      = eng_release_i && r_bank_valid[w_rd_ptr];
  assign w_last     = (r_fetched + 16'd1) == r_n_sets;
  assign w_cap_mask = w_cap ? (NB'(1) << w_wr_ptr) : '0;
  assign w_rel_mask = w_rel ? (NB'(1) << w_rd_ptr) : '0;

`ifdef HWCE_WBUF_DOUBLE_EN
  logic r_wr_ptr;
  logic r_rd_ptr;

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      if (w_cap) r_wr_ptr <= ~r_wr_ptr;
      if (w_rel) r_rd_ptr <= ~r_rd_ptr;
    end
  end

  assign w_wr_ptr = r_wr_ptr;
  assign w_rd_ptr = r_rd_ptr;
  // bank we write next is free now or is being released this cycle
  assign w_other_free = !r_bank_valid[~r_wr_ptr]
                        || (w_rel && (r_rd_ptr != r_wr_ptr));
`else
  assign w_wr_ptr     = 1'b0;
  assign w_rd_ptr     = 1'b0;
  assign w_other_free = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (w_clr) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:      if (w_start_ok) w_next = S_ISSUE;
      S_ISSUE:     w_next = S_LOADING;
      S_LOADING: begin
        if (w_cap) begin
          if (w_last)            w_next = S_DRAIN;
          else if (w_other_free) w_next = S_ISSUE;
          else                   w_next = S_WAIT_FREE;
        end
      end
      S_WAIT_FREE: if (!r_bank_valid[w_wr_ptr]) w_next = S_ISSUE;
      S_DRAIN:     if (r_released == r_n_sets) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_comb begin
    wl_start_o = 1'b0;
    busy_o     = 1'b0;
    job_done_o = r_zero_done;
    unique case (r_state)
      S_IDLE: ;
      S_ISSUE: begin
        wl_start_o = 1'b1;
        busy_o     = 1'b1;
      end
      S_LOADING, S_WAIT_FREE: busy_o = 1'b1;
      S_DRAIN: begin
        if (r_released == r_n_sets) job_done_o = 1'b1;
        else                        busy_o     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_n_sets     <= 16'd0;
      r_fetched    <= 16'd0;
      r_released   <= 16'd0;
      r_bank_valid <= '0;
      r_zero_done  <= 1'b0;
      for (int i = 0; i < NB; i++) begin
        r_w[i] <= '0;
        r_b[i] <= '0;
      end
    end else begin
      r_zero_done <= (r_state == S_IDLE) && job_start_i
                     && (n_sets_i == 16'd0);
      if (w_start_ok) begin
        r_n_sets   <= n_sets_i;
        r_fetched  <= 16'd0;
        r_released <= 16'd0;
      end else begin
        if (w_cap) r_fetched  <= r_fetched + 16'd1;
        if (w_rel) r_released <= r_released + 16'd1;
      end
      r_bank_valid <= (r_bank_valid & ~w_rel_mask) | w_cap_mask;
      if (w_cap) begin
        r_w[w_wr_ptr] <= wl_weights_i;
        r_b[w_wr_ptr] <= wl_bias_i;
      end
    end
  end

  assign eng_valid_o   = r_bank_valid[w_rd_ptr];
  assign eng_weights_o = r_w[w_rd_ptr];
  assign eng_bias_o    = r_b[w_rd_ptr];
  assign eng_set_idx_o = r_released;

endmodule

// File: tb/tb_hwce_weight_buffer.sv
// Scoreboard bench for hwce_weight_buffer with a behavioural weight loader.
// Expectations follow HWCE_WBUF_DOUBLE_EN when defined.
module tb_hwce_weight_buffer;
  localparam int FS  = 3;
  localparam int NR  = 4;
  localparam int NC  = 4;
  localparam int NPF = 3;
  localparam int K   = FS * FS * NPF;
  localparam int NW  = NR * NC * K;
  localparam int WW  = NW * 16;
  localparam int BW  = NR * 16;
`ifdef HWCE_WBUF_DOUBLE_EN
  localparam int DBL = 1;
`else
  localparam int DBL = 0;
`endif

  logic          clk;
  logic          rst;
  logic          job_start_i;
  logic [15:0]   n_sets_i;
  logic          clear_i;
  logic          wl_start_o;
  logic          wl_done_i;
  logic [WW-1:0] wl_weights_i;
  logic [BW-1:0] wl_bias_i;
  logic          eng_valid_o;
  logic [WW-1:0] eng_weights_o;
  logic [BW-1:0] eng_bias_o;
  logic [15:0]   eng_set_idx_o;
  logic          eng_release_i;
  logic          busy_o;
  logic          job_done_o;

  hwce_weight_buffer #(
    .FILTER_SIZE(FS),
    .N_ROW(NR),
    .N_COL(NC),
    .NPF(NPF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .job_start_i(job_start_i),
    .n_sets_i(n_sets_i),
    .clear_i(clear_i),
    .wl_start_o(wl_start_o),
    .wl_done_i(wl_done_i),
    .wl_weights_i(wl_weights_i),
    .wl_bias_i(wl_bias_i),
    .eng_valid_o(eng_valid_o),
    .eng_weights_o(eng_weights_o),
    .eng_bias_o(eng_bias_o),
    .eng_set_idx_o(eng_set_idx_o),
    .eng_release_i(eng_release_i),
    .busy_o(busy_o),
    .job_done_o(job_done_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [WW-1:0] mk_w(input int s);
    logic [WW-1:0] w;
    for (int i = 0; i < NW; i++) w[i*16 +: 16] = 16'(s * 257 + i * 3 + 1);
    return w;
  endfunction

  function automatic logic [BW-1:0] mk_b(input int s);
    logic [BW-1:0] b;
    for (int r = 0; r < NR; r++) b[r*16 +: 16] = 16'(s * 13 + r + 1);
    return b;
  endfunction

  function automatic int unsigned fold(input logic [WW-1:0] w);
    int unsigned s = 0;
    for (int i = 0; i < NW; i++) s = s * 31 + 32'(w[i*16 +: 16]);
    return s;
  endfunction

  int unsigned   q_wsum [$];
  logic [BW-1:0] q_bias [$];
  int            q_idx  [$];
  int lat      = 20;
  int n_starts = 0;
  int ld_idx   = 0;
  int seed     = 1;

  // loader model: answers every start pulse after lat cycles
  initial begin
    wl_done_i    = 1'b0;
    wl_weights_i = '0;
    wl_bias_i    = '0;
    forever begin
      @(negedge clk);
      if (wl_start_o) begin
        n_starts++;
        repeat (lat) @(posedge clk);
        #1;
        wl_done_i    = 1'b1;
        wl_weights_i = mk_w(seed);
        wl_bias_i    = mk_b(seed);
        q_wsum.push_back(fold(mk_w(seed)));
        q_bias.push_back(mk_b(seed));
        q_idx.push_back(ld_idx);
        ld_idx++;
        seed++;
        @(posedge clk);
        #1;
        wl_done_i = 1'b0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (eng_release_i && eng_valid_o) begin
      chk("sb_nonempty", 64'(q_wsum.size() != 0), 1);
      if (q_wsum.size() != 0) begin
        chk("sb_wsum", fold(eng_weights_o), q_wsum.pop_front());
        chk("sb_bias", eng_bias_o, q_bias.pop_front());
        chk("sb_idx", eng_set_idx_o, q_idx.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int n, output int t0);
    tick();
    job_start_i = 1'b1;
    n_sets_i    = 16'(n);
    ld_idx      = 0;
    t0          = cyc;
    tick();
    job_start_i = 1'b0;
  endtask

  task automatic wait_valid(input string tag, output int c);
    bit ok = 1'b0;
    c = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (eng_valid_o) begin
        ok = 1'b1;
        c  = cyc;
        break;
      end
    end
    chk(tag, ok, 1);
  endtask

  task automatic rel_one();
    tick();
    eng_release_i = 1'b1;
    tick();
    eng_release_i = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (job_done_o) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, ok, 1);
  endtask

  int t0;
  int c;
  int s0;
  int unsigned exp_w;

  initial begin
    rst           = 1'b1;
    job_start_i   = 1'b0;
    n_sets_i      = 16'd0;
    clear_i       = 1'b0;
    eng_release_i = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // reset and idle
    repeat (5) tick();
    chk("rst_valid", eng_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", job_done_o, 0);
    chk("rst_idx", eng_set_idx_o, 0);
    chk("rst_bias", eng_bias_o, 0);
    chk("rst_wsum", fold(eng_weights_o), fold('0));
    chk("rst_starts", n_starts, 0);

    // single set, loader latency 20
    lat = 20;
    start_job(1, t0);
    chk("start_lat", wl_start_o, 1);
    wait_valid("t2_valid", c);
    chk("valid_lat", c - t0, 22);
    chk("t2_busy", busy_o, 1);
    repeat (9) tick();
    rel_one();
    chk("jd_pulse", job_done_o, 1);
    chk("busy_drop", busy_o, 0);
    tick();
    chk("jd_once", job_done_o, 0);
    chk("t2_starts", n_starts, 1);

    // three sets with release held off
    lat = 8;
    s0  = n_starts;
    start_job(3, t0);
    repeat (40) tick();
    chk("held_starts", n_starts - s0, 1 + DBL);
    chk("held_valid", eng_valid_o, 1);
    chk("held_busy", busy_o, 1);
    rel_one();
    chk("nogap_valid", eng_valid_o, DBL);
    chk("nogap_idx", eng_set_idx_o, 1);
    for (int i = 0; i < 2; i++) begin
      wait_valid("t3_valid", c);
      rel_one();
    end
    wait_done("t3_done");
    chk("t3_starts", n_starts - s0, 3);
    chk("t3_drained", q_wsum.size(), 0);

    // capture of set 1 together with release of set 0
    s0 = n_starts;
    start_job(2, t0);
    wait_valid("t4_valid0", c);
`ifdef HWCE_WBUF_DOUBLE_EN
    repeat (7) tick();
    rel_one();
    exp_w = (q_wsum.size() != 0) ? q_wsum[0] : 0;
    chk("sim_valid", eng_valid_o, 1);
    chk("sim_idx", eng_set_idx_o, 1);
    chk("sim_data", fold(eng_weights_o), exp_w);
`else
    rel_one();
    chk("single_drop", eng_valid_o, 0);
    chk("single_idx", eng_set_idx_o, 1);
    wait_valid("t4_valid1", c);
`endif
    rel_one();
    wait_done("t4_done");
    chk("t4_starts", n_starts - s0, 2);
    chk("t4_drained", q_wsum.size(), 0);

    // empty job, then release with nothing valid
    s0 = n_starts;
    start_job(0, t0);
    chk("zero_done", job_done_o, 1);
    chk("zero_busy", busy_o, 0);
    tick();
    chk("zero_once", job_done_o, 0);
    repeat (5) tick();
    chk("zero_starts", n_starts - s0, 0);
    chk("idx_pre", eng_set_idx_o, 2);
    rel_one();
    tick();
    chk("idx_ign", eng_set_idx_o, 2);
    chk("ign_valid", eng_valid_o, 0);

    // clear during LOADING, stray done afterwards
    s0 = n_starts;
    start_job(1, t0);
    repeat (2) tick();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    repeat (12) tick();
    chk("clr_busy", busy_o, 0);
    chk("clr_valid", eng_valid_o, 0);
    chk("clr_idx", eng_set_idx_o, 0);
    chk("clr_start", wl_start_o, 0);
    chk("clr_starts", n_starts - s0, 1);
    q_wsum.delete();
    q_bias.delete();
    q_idx.delete();
    s0 = n_starts;
    start_job(2, t0);
    for (int i = 0; i < 2; i++) begin
      wait_valid("t6_valid", c);
      rel_one();
    end
    wait_done("t6_done");
    chk("t6_starts", n_starts - s0, 2);
    chk("t6_drained", q_wsum.size(), 0);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hwce_weight_buffer.md
Name: hwce_weight_buffer

Overview:
- Double-buffered weight/bias holding stage directly downstream of the HWCE weight loader.
- Drives the loader's start, captures its weight/bias outputs into a free bank on done, and presents a stable set to the sum-of-products engines.
- Prefetches set k+1 while the engines consume set k, for a job of n_sets_i weight sets.

Parameters:
- FILTER_SIZE, 3, filter side length.
- N_ROW, 4, engine rows (one bias each).
- N_COL, 4, engine columns.
- NPF, 3, parallel filters per engine; K = FILTER_SIZE*FILTER_SIZE*NPF weights per engine.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock, synchronous, active-high.
- job_start_i  in  1  pulse; starts a job; sampled only in IDLE.
- n_sets_i  in  16  sets in the job; sampled with job_start_i.
- clear_i  in  1  synchronous flush, same effect as rst.
- wl_start_o  out  1  one-cycle start pulse to the loader.
- wl_done_i  in  1  loader done pulse; wl_weights_i/wl_bias_i valid in that cycle.
- wl_weights_i  in  N_ROW*N_COL*K*16  packed [row][col][k][15:0].
- wl_bias_i  in  N_ROW*16  packed [row][15:0].
- eng_valid_o  out  1  active bank holds a valid set.
- eng_weights_o  out  N_ROW*N_COL*K*16  active bank weights (registered storage).
- eng_bias_o  out  N_ROW*16  active bank biases.
- eng_set_idx_o  out  16  index (0-based) of the set in the active bank.
- eng_release_i  in  1  pulse; engines finished with the active set.
- busy_o  out  1  high from accepted job_start_i until job_done_o.
- job_done_o  out  1  pulse; last set released.

Behaviour:
- Reset/clear: state IDLE, bank_valid=00, wr/rd pointers 0, counters 0. All outputs 0; bank contents 0.
- Fetch FSM states: IDLE, ISSUE, LOADING, WAIT_FREE, DRAIN.
  - IDLE, job_start_i with n_sets_i!=0: latch n_sets, fetched=0, released=0, busy_o=1, go to ISSUE.
  - IDLE, job_start_i with n_sets_i==0: job_done_o pulses next cycle; stay IDLE; busy_o stays 0.
  - ISSUE: wl_start_o=1 for exactly this cycle, then go to LOADING.
  - LOADING, wl_done_i: write inputs into bank[wr_ptr], set its valid bit, toggle wr_ptr, fetched++.
    - If fetched (after increment) == n_sets: go to DRAIN.
    - Else if the other bank is free in the next cycle: go to ISSUE.
    - Else: go to WAIT_FREE.
  - WAIT_FREE: go to ISSUE in the cycle after bank[wr_ptr] becomes invalid.
  - DRAIN, released == n_sets: go to IDLE, job_done_o=1 for one cycle, busy_o=0.
- job_start_i outside IDLE is ignored. wl_done_i outside LOADING is ignored.
- Latency:
  - job_start_i at cycle 0 gives wl_start_o at cycle 1.
  - wl_done_i at cycle N gives eng_valid_o=1 at N+1 when the bank becomes active.
- Consume side:
  - eng_valid_o = bank_valid[rd_ptr].
  - eng_release_i while eng_valid_o=1: clear bank_valid[rd_ptr], toggle rd_ptr, released++, eng_set_idx_o++ (next cycle).
  - eng_release_i while eng_valid_o=0: ignored.
- If the other bank is already valid at release, eng_valid_o stays 1 and the data switches next cycle; no bubble.
- Simultaneous capture and release in one cycle: both take effect. Capture always targets the non-active free bank, so the write and the release never touch the same bank.
- Active-bank outputs never change while eng_valid_o=1 and no release occurs.
- Counters are 16-bit; n_sets up to 65535. No wrap within a job.
- Reset or clear mid-LOADING: a subsequent stray wl_done_i is ignored (FSM in IDLE).

Optional Feature:
- Macro HWCE_WBUF_DOUBLE_EN.
- Defined: two banks, prefetch behaviour as above.
- Undefined: single bank; wr_ptr/rd_ptr fixed at 0.
  - After capture, the FSM goes to WAIT_FREE (or DRAIN on the last set).
  - ISSUE follows only after release, so there is never overlap between fetch and compute.
  - Bank storage area is halved.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0; wl_start_o never asserts.
- job_start_i with n_sets_i=1, done 20 cycles after start, release 10 cycles later -> wl_start_o cycle 1; eng_valid_o rises cycle 22 with weights/bias equal to the injected pattern; job_done_o pulses one cycle after release; busy_o drops with it.
- n_sets_i=3 (double), done latency 8, release held off -> sets 0 and 1 captured, FSM in WAIT_FREE with no third wl_start_o; first release -> eng_set_idx_o=1 with no eng_valid_o gap; third wl_start_o follows; after 3 releases job_done_o pulses.
- Capture of set 1 in the same cycle as release of set 0 -> next cycle eng_valid_o=1, eng_set_idx_o=1, set-1 data.
- n_sets_i=0 -> job_done_o pulses one cycle later; no wl_start_o. Also eng_release_i with eng_valid_o=0 -> counters unchanged.
- clear_i asserted during LOADING, then wl_done_i pulse -> state IDLE, eng_valid_o=0, capture ignored. New job_start_i with n_sets_i=2 then runs normally.
